// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the writeback register file: FSM encoding,
// register-index width, register count and the stack-pointer index.
package writeback_regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int REG_IDX_W = 5;
  localparam int REG_COUNT = 32;
  localparam int SP_IDX    = 2;

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback/decode side bundle of the register file: one write port from
// writeback, two read ports to decode and the init_busy hold indication.
interface writeback_regfile_if
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  write;
  logic [REG_IDX_W-1:0]  write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [REG_IDX_W-1:0]  read_sel1;
  logic [REG_IDX_W-1:0]  read_sel2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  init_busy;

  modport master (
    output write, write_reg, write_data, read_sel1, read_sel2,
    input  read_data1, read_data2, init_busy
  );

  modport slave (
    input  write, write_reg, write_data, read_sel1, read_sel2,
    output read_data1, read_data2, init_busy
  );

endinterface

// File: rtl/writeback_regfile_read_port.sv
// One combinational read port: forces x0 and the CLEAR state to zero and,
// when REGFILE_BYPASS_EN is defined, forwards a same-cycle write.
module regfile_read_port
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_stored,
  input  logic [REG_IDX_W-1:0]  i_sel,
  input  rf_state_e             i_state,
  input  logic                  i_write,
  input  logic [REG_IDX_W-1:0]  i_write_reg,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] o_data
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic w_fwd;

  assign w_fwd = BYPASS_EN && i_write && (i_write_reg != '0) && (i_write_reg == i_sel);

  always_comb begin
    o_data = '0;
    if (i_state == READY && i_sel != '0) begin
      o_data = w_fwd ? i_write_data : i_stored;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Integer register file fed by writeback; an initialisation walk after each
// reset zeroes x1..x31 and loads x2 with SP_INIT. Optional macro: REGFILE_BYPASS_EN.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int                    CORE             = 0,
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] SP_INIT          = 32'h0000_3FF0,
  parameter int                    PRINT_CYCLES_MIN = 1,
  parameter int                    PRINT_CYCLES_MAX = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                report,
  writeback_regfile_if.slave  wb
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(REG_COUNT - 1);
  localparam logic [REG_IDX_W-1:0] SP_SEL   = REG_IDX_W'(SP_IDX);
  localparam logic [31:0]          CYC_MIN  = 32'(PRINT_CYCLES_MIN);
  localparam logic [31:0]          CYC_MAX  = 32'(PRINT_CYCLES_MAX);

  rf_state_e             r_state;
  logic [REG_IDX_W-1:0]  r_idx;
  logic [31:0]           r_cycles;
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  // Control: walk index, state and cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= CLEAR;
      r_idx    <= REG_IDX_W'(1);
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (r_state == CLEAR) begin
        if (r_idx == LAST_IDX) r_state <= READY;
        else                   r_idx   <= r_idx + REG_IDX_W'(1);
      end
    end
  end

  // Storage is left untouched while reset is high; writes during CLEAR are dropped
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_regs[r_idx] <= (r_idx == SP_SEL) ? SP_INIT : '0;
      end else if (wb.write && wb.write_reg != '0) begin
        r_regs[wb.write_reg] <= wb.write_data;
      end
    end
  end

  assign wb.init_busy = reset | (r_state == CLEAR);

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_rd1 (
    .i_stored     (r_regs[wb.read_sel1]),
    .i_sel        (wb.read_sel1),
    .i_state      (r_state),
    .i_write      (wb.write),
    .i_write_reg  (wb.write_reg),
    .i_write_data (wb.write_data),
    .o_data       (wb.read_data1)
  );

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_rd2 (
    .i_stored     (r_regs[wb.read_sel2]),
    .i_sel        (wb.read_sel2),
    .i_state      (r_state),
    .i_write      (wb.write),
    .i_write_reg  (wb.write_reg),
    .i_write_data (wb.write_data),
    .o_data       (wb.read_data2)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report && r_cycles >= CYC_MIN && r_cycles <= CYC_MAX) begin
      $display("[core %0d] cyc=%0d st=%s wr=%b rd=%0d wd=%h | s1=%0d d1=%h s2=%0d d2=%h",
               CORE, r_cycles, r_state.name(), wb.write, wb.write_reg, wb.write_data,
               wb.read_sel1, wb.read_data1, wb.read_sel2, wb.read_data2);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: init walk length,
// SP load, write/read, x0 discard, bypass, CLEAR-write discard, mid-run reset.
module tb_writeback_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic report;
  int   n_tests = 0;
  int   n_fail  = 0;

  writeback_regfile_if #(.DATA_WIDTH(32)) wb ();

  writeback_regfile #(
    .CORE(0), .DATA_WIDTH(32), .SP_INIT(32'h0000_3FF0),
    .PRINT_CYCLES_MIN(1), .PRINT_CYCLES_MAX(1000)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .report (report),
    .wb     (wb)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Walks until init_busy drops; optionally injects a write at walk cycle 10.
  task automatic walk(input bit inject, output int n);
    n = 0;
    while (n < 100) begin
      if (inject && n == 9) begin
        wb.write = 1'b1; wb.write_reg = 5'd3; wb.write_data = 32'hAA;
      end
      tick();
      n++;
      wb.write = 1'b0;
      if (n == 20) begin
        wb.read_sel1 = 5'd2;
        settle();
        check_val("clear_read_zero", wb.read_data1, 32'h0);
      end
      if (!wb.init_busy) break;
    end
  endtask

  task automatic do_write(input logic [4:0] r, input logic [31:0] d);
    wb.write = 1'b1; wb.write_reg = r; wb.write_data = d;
    tick();
    wb.write = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; report = 1'b0;
    wb.write = 1'b0; wb.write_reg = '0; wb.write_data = '0;
    wb.read_sel1 = 5'd2; wb.read_sel2 = 5'd5;
    tick();
    tick();
    check_val("rst_busy", 32'(wb.init_busy), 32'd1);
    check_val("rst_rd1", wb.read_data1, 32'h0);
    check_val("rst_rd2", wb.read_data2, 32'h0);

    reset = 1'b0;
    settle();
    check_val("busy_after_release", 32'(wb.init_busy), 32'd1);
    walk(1'b1, n);
    check_val("walk_len", 32'(n), 32'd31);

    wb.read_sel1 = 5'd2; wb.read_sel2 = 5'd5;
    settle();
    check_val("sp_init", wb.read_data1, 32'h0000_3FF0);
    check_val("x5_zero", wb.read_data2, 32'h0);
    wb.read_sel1 = 5'd3;
    settle();
    check_val("clear_write_dropped", wb.read_data1, 32'h0);

    do_write(5'd7, 32'hDEAD_BEEF);
    wb.read_sel1 = 5'd7; wb.read_sel2 = 5'd7;
    settle();
    check_val("x7_p1", wb.read_data1, 32'hDEAD_BEEF);
    check_val("x7_p2", wb.read_data2, 32'hDEAD_BEEF);

    do_write(5'd0, 32'h1234);
    wb.read_sel1 = 5'd0;
    settle();
    check_val("x0_zero", wb.read_data1, 32'h0);

    // Same-cycle write of x9 seen on port 1 only; port 2 watches x7
    wb.read_sel1 = 5'd9; wb.read_sel2 = 5'd7;
    wb.write = 1'b1; wb.write_reg = 5'd9; wb.write_data = 32'h55;
    settle();
    check_val("x9_same_cycle", wb.read_data1, BYP ? 32'h55 : 32'h0);
    check_val("x9_other_port", wb.read_data2, 32'hDEAD_BEEF);
    tick();
    wb.write = 1'b0;
    settle();
    check_val("x9_next_cycle", wb.read_data1, 32'h55);

    wb.read_sel1 = 5'd0;
    wb.write = 1'b1; wb.write_reg = 5'd0; wb.write_data = 32'hFFFF;
    settle();
    check_val("x0_no_bypass", wb.read_data1, 32'h0);
    tick();
    wb.write = 1'b0;

    do_write(5'd4, 32'h77);
    wb.read_sel1 = 5'd4;
    settle();
    check_val("x4_written", wb.read_data1, 32'h77);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check_val("rerst_busy", 32'(wb.init_busy), 32'd1);
    wb.read_sel1 = 5'd4;
    settle();
    check_val("rerst_read_zero", wb.read_data1, 32'h0);
    walk(1'b0, n);
    check_val("rewalk_len", 32'(n), 32'd31);
    wb.read_sel1 = 5'd4; wb.read_sel2 = 5'd2;
    settle();
    check_val("x4_cleared", wb.read_data1, 32'h0);
    check_val("x2_reloaded", wb.read_data2, 32'h0000_3FF0);
    wb.read_sel1 = 5'd7;
    settle();
    check_val("x7_cleared", wb.read_data1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Integer register file at the receiving end of the writeback interface. It accepts the `write` / `write_reg` / `write_data` triple produced by the writeback stage and serves two combinational read ports to decode. After every reset it runs a sequential initialisation walk. The walk zeroes x1..x31 and loads the stack pointer (x2) with a configured value. It reports `init_busy` so the pipeline holds until the file is valid.

## Interface
Parameters:
- `CORE`, 0, core index printed in report output
- `DATA_WIDTH`, 32, register width in bits
- `SP_INIT`, 32'h0000_3FF0, value loaded into x2 by the initialisation walk
- `PRINT_CYCLES_MIN`, 1, first cycle eligible for report output
- `PRINT_CYCLES_MAX`, 1000, last cycle eligible for report output

Ports:
- `clock`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `write`  in  1  write enable from writeback
- `write_reg`  in  5  destination register index
- `write_data`  in  DATA_WIDTH  value to write
- `read_sel1`  in  5  read port 1 index
- `read_sel2`  in  5  read port 2 index
- `read_data1`  out  DATA_WIDTH  read port 1 data
- `read_data2`  out  DATA_WIDTH  read port 2 data
- `init_busy`  out  1  high while reset is asserted or the initialisation walk is running
- `report`  in  1  enables per-cycle $display dump

## Operation
- FSM states: CLEAR, READY.
- Reset: state <= CLEAR, idx <= 1, cycle counter <= 0. Storage is not touched while reset is high.
- CLEAR behaviour, per posedge with reset low:
  - reg[idx] <= (idx == 2) ? SP_INIT : 0.
  - idx <= idx + 1.
  - After reg[31] is written, state <= READY.
- The 5-bit idx never wraps: 31 is the terminal index, and idx is held once READY.
- READY: on a posedge with `write` = 1 and `write_reg` != 0, reg[write_reg] <= write_data.
- Writes with `write_reg` = 0 are discarded.
- Writes in CLEAR (any index) are discarded. Upstream must hold on `init_busy`.
- Reads are combinational:
  - Index 0 returns 0.
  - In CLEAR, both ports return 0 regardless of index.
- Both read ports may select the same index. Each port resolves independently.
- `init_busy` = reset | (state == CLEAR).
- Report: on each posedge with `report` = 1 and cycles in [PRINT_CYCLES_MIN, PRINT_CYCLES_MAX], display:
  - core, cycle, state
  - write, write_reg, write_data
  - both read selects and read data

## Timing
- Reset values:
  - `init_busy` = 1
  - `read_data1` = `read_data2` = 0, because the FSM is in CLEAR
- Initialisation length: exactly 31 posedges after the first cycle with reset low. `init_busy` falls after the 31st.
- Reset asserted mid-walk or in READY: on the next posedge, state = CLEAR and idx = 1, and the full walk restarts.
- Write latency: data is visible on a read port in the cycle after the write posedge. Same-cycle visibility depends on the configuration below.
- The file applies no stall. The `write` input alone qualifies a commit.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In READY, if `write` = 1, `write_reg` != 0 and `write_reg` == `read_selN`, then `read_dataN` = `write_data` in the same cycle.
  - Forwarding applies per port, independently.
- Undefined: reads return the stored (pre-write) value until the posedge commits the write.

## Structure
- Shared package holds:
  - the FSM state encoding (CLEAR, READY)
  - the register-index width (5)
  - the register count (32)
  - the SP index constant (2)
- One sub-module, `regfile_read_port`, instantiated twice. It takes the stored value, the index and the write-side signals, and applies:
  - zero for index 0
  - zero during CLEAR
  - the optional bypass

## Test plan
- Reset for 2 cycles then release:
  - `init_busy` = 1 for exactly 31 posedges after release.
  - Afterwards, `read_sel1` = 2 returns 32'h3FF0, and `read_sel2` = 5 returns 0.
- In READY, write x7 = 32'hDEAD_BEEF, then read x7 on both ports next cycle -> both return 32'hDEAD_BEEF.
- Write x0 = 32'h1234 -> reading x0 returns 0 on the following cycle.
- Write x9 = 32'h55 with `read_sel1` = 9 in the same cycle:
  - With `REGFILE_BYPASS_EN`: 32'h55 in the same cycle.
  - Without it: the old value in the same cycle, then 32'h55 next cycle.
- Write x3 = 32'hAA during CLEAR (cycle 10 of walk) -> x3 reads 0 after `init_busy` falls.
- Write x4 = 32'h77 in READY, then assert reset for 1 cycle mid-operation:
  - `init_busy` returns high for 31 posedges after release.
  - x4 then reads 0, and x2 reads SP_INIT.
